// File: rtl/spart_tx_queue.sv
`timescale 1ns/1ps
// Transmit queue between the processor send path and the SPART.
// Buffers byte/word entries and drains them one byte per cycle, low byte first.
module spart_tx_queue #(
    parameter int ADDR_W = 3,
    parameter int BYTE_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [2*BYTE_W-1:0] push_data,
    input  logic                push_word,
    input  logic                flush,
    input  logic                spart_full,
    output logic                push_ready,
    output logic [ADDR_W:0]     count,
    output logic                empty,
    output logic                idle,
    output logic                overflow,
    output logic                send,
    output logic [BYTE_W-1:0]   send_data
);

    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int ENTRY_W = 2 * BYTE_W + 1;

    typedef enum logic {
        IDLE,
        HI_PEND
    } state_t;

    state_t              state, state_next;
    logic [ENTRY_W-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
    logic [ADDR_W:0]     count_q;
    logic [BYTE_W-1:0]   held_hi, held_hi_next;
    logic [ENTRY_W-1:0]  head;
    logic                push_acc, pop, send_next;
    logic [BYTE_W-1:0]   send_data_next;

    // Status flags come only from registered state, never from inputs.
    assign push_ready = count_q < (ADDR_W+1)'(DEPTH);
    assign empty      = (count_q == '0);
    assign idle       = empty && (state == IDLE);
    assign count      = count_q;
    assign head       = mem[rd_ptr];
    assign push_acc   = push && push_ready && !flush;

    always_comb begin
        state_next     = state;
        held_hi_next   = held_hi;
        pop            = 1'b0;
        send_next      = 1'b0;
        send_data_next = send_data;
        if (!spart_full) begin
            case (state)
                HI_PEND: begin
                    send_next      = 1'b1;
                    send_data_next = held_hi;
                    state_next     = IDLE;
                end
                IDLE: begin
                    if (!empty) begin
                        pop            = 1'b1;
                        send_next      = 1'b1;
                        send_data_next = head[BYTE_W-1:0];
                        if (head[ENTRY_W-1]) begin
                            state_next   = HI_PEND;
                            held_hi_next = head[2*BYTE_W-1:BYTE_W];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr] <= {push_word, push_data};
        end
    end

    // Flush clears queue and serializer but keeps the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            state     <= IDLE;
            held_hi   <= '0;
            overflow  <= 1'b0;
            send      <= 1'b0;
            send_data <= '0;
        end else begin
            if (push && !push_ready) begin
                overflow <= 1'b1;
            end
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
                state   <= IDLE;
                send    <= 1'b0;
            end else begin
                state     <= state_next;
                held_hi   <= held_hi_next;
                send      <= send_next;
                send_data <= send_data_next;
                if (push_acc) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count_q <= count_q + (ADDR_W+1)'(push_acc) - (ADDR_W+1)'(pop);
            end
        end
    end

endmodule

// File: tb/tb_spart_tx_queue.sv
`timescale 1ns/1ps
// Bench for spart_tx_queue: queue-level reference model plus a byte scoreboard
// popped by a monitor whenever the DUT strobes send.
module tb_spart_tx_queue;

    localparam int ADDR_W = 3;
    localparam int BYTE_W = 8;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              push = 1'b0;
    logic [15:0]       push_data = '0;
    logic              push_word = 1'b0;
    logic              flush = 1'b0;
    logic              spart_full = 1'b0;
    logic              push_ready;
    logic [ADDR_W:0]   count;
    logic              empty;
    logic              idle;
    logic              overflow;
    logic              send;
    logic [7:0]        send_data;

    always #5 clk = ~clk;

    spart_tx_queue #(.ADDR_W(ADDR_W), .BYTE_W(BYTE_W)) dut (
        .clk(clk), .rst(rst), .push(push), .push_data(push_data),
        .push_word(push_word), .flush(flush), .spart_full(spart_full),
        .push_ready(push_ready), .count(count), .empty(empty), .idle(idle),
        .overflow(overflow), .send(send), .send_data(send_data)
    );

    typedef struct {
        logic [15:0] data;
        bit          word;
    } entry_t;

    entry_t     m_q[$];
    logic [7:0] exp_q[$];
    bit         m_owed = 0;
    logic [7:0] m_owed_byte = '0;
    bit         m_ovf = 0;
    bit         m_send = 0;
    logic [7:0] m_last = '0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    bit         mon_en = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input bit p, input logic [15:0] d, input bit w,
                                 input bit f, input bit full);
        push       = p;
        push_data  = d;
        push_word  = w;
        flush      = f;
        spart_full = full;
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference model: a queue of whole entries plus one owed high byte.
    initial forever begin
        entry_t e;
        bit     ready;
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            exp_q.delete();
            m_owed = 0;
            m_ovf  = 0;
            m_send = 0;
            m_last = '0;
        end else begin
            ready = (m_q.size() < DEPTH);
            if (push && !ready) m_ovf = 1;
            if (flush) begin
                m_q.delete();
                exp_q.delete();
                m_owed = 0;
                m_send = 0;
            end else begin
                m_send = 0;
                if (!spart_full) begin
                    if (m_owed) begin
                        m_send = 1;
                        m_last = m_owed_byte;
                        m_owed = 0;
                    end else if (m_q.size() > 0) begin
                        e      = m_q.pop_front();
                        m_send = 1;
                        m_last = e.data[7:0];
                        if (e.word) begin
                            m_owed      = 1;
                            m_owed_byte = e.data[15:8];
                        end
                    end
                end
                if (push && ready) begin
                    e.data = push_data;
                    e.word = push_word;
                    m_q.push_back(e);
                    exp_q.push_back(push_data[7:0]);
                    if (push_word) exp_q.push_back(push_data[15:8]);
                end
            end
        end
    end

    // Monitor: compares every cycle and pops the scoreboard on each send.
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            checkOutput("send", send, m_send);
            if (send === 1'b1) begin
                if (exp_q.size() == 0) checkOutput("send_unexpected", 1, 0);
                else checkOutput("send_data", send_data, exp_q.pop_front());
            end else begin
                checkOutput("send_data_hold", send_data, m_last);
            end
            checkOutput("count", count, m_q.size());
            checkOutput("empty", empty, m_q.size() == 0);
            checkOutput("idle", idle, (m_q.size() == 0) && !m_owed);
            checkOutput("push_ready", push_ready, m_q.size() < DEPTH);
            checkOutput("overflow", overflow, m_ovf);
        end
    end

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_send"}, send, 0);
        checkOutput({tag, "_send_data"}, send_data, 0);
        checkOutput({tag, "_count"}, count, 0);
        checkOutput({tag, "_empty"}, empty, 1);
        checkOutput({tag, "_idle"}, idle, 1);
        checkOutput({tag, "_push_ready"}, push_ready, 1);
        checkOutput({tag, "_overflow"}, overflow, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        checkResetValues("reset");
        repeat (2) applyStimulus(0, 16'h0, 0, 0, 0);

        // Single byte: send exactly two cycles after the push.
        applyStimulus(1, 16'h1234, 0, 0, 0);
        checkOutput("lat_t1_send", send, 0);
        applyStimulus(0, 16'h0, 0, 0, 0);
        checkOutput("lat_t2_send", send, 1);
        checkOutput("lat_t2_data", send_data, 8'h34);
        applyStimulus(0, 16'h0, 0, 0, 0);
        checkOutput("lat_t3_send", send, 0);
        checkOutput("lat_t3_idle", idle, 1);

        // Word entry: low byte then high byte on consecutive cycles.
        applyStimulus(1, 16'hABCD, 1, 0, 0);
        applyStimulus(0, 16'h0, 0, 0, 0);
        checkOutput("word_lo", send_data, 8'hCD);
        applyStimulus(0, 16'h0, 0, 0, 0);
        checkOutput("word_hi_send", send, 1);
        checkOutput("word_hi", send_data, 8'hAB);
        applyStimulus(0, 16'h0, 0, 0, 0);
        checkOutput("word_done_send", send, 0);
        checkOutput("word_done_count", count, 0);

        // Fill with SPART blocked: eighth push fills, ninth overflows.
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(1, 16'(i), 0, 0, 1);
            if (i == 8) begin
                checkOutput("fill_push_ready", push_ready, 0);
                checkOutput("fill_count", count, 8);
                checkOutput("fill_no_ovf", overflow, 0);
            end
        end
        checkOutput("fill_ovf", overflow, 1);
        checkOutput("fill_count9", count, 8);
        repeat (12) applyStimulus(0, 16'h0, 0, 0, 0);
        checkOutput("fill_drained", exp_q.size(), 0);

        // High byte held while SPART is full.
        applyStimulus(1, 16'h5566, 1, 0, 0);
        applyStimulus(0, 16'h0, 0, 0, 0);
        checkOutput("hold_lo", send_data, 8'h66);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 16'h0, 0, 0, 1);
            checkOutput("hold_send", send, 0);
            checkOutput("hold_idle", idle, 0);
        end
        applyStimulus(0, 16'h0, 0, 0, 0);
        checkOutput("hold_hi_send", send, 1);
        checkOutput("hold_hi", send_data, 8'h55);
        applyStimulus(0, 16'h0, 0, 0, 0);

        // Flush with a held high byte, three queued entries and a push.
        applyStimulus(1, 16'h7788, 1, 0, 0);
        applyStimulus(0, 16'h0, 0, 0, 0);
        for (int k = 1; k <= 3; k++) applyStimulus(1, 16'(k * 16'h0101), 0, 0, 1);
        checkOutput("preflush_count", count, 3);
        applyStimulus(1, 16'hEEEE, 1, 1, 1);
        checkOutput("flush_count", count, 0);
        checkOutput("flush_idle", idle, 1);
        checkOutput("flush_send", send, 0);
        checkOutput("flush_ovf_kept", overflow, 1);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 16'h0, 0, 0, 0);
            checkOutput("post_flush_send", send, 0);
        end

        // Reset in the middle of a drain clears overflow too.
        for (int k = 0; k < 5; k++) applyStimulus(1, 16'(16'h0A00 + k), 1, 0, 1);
        repeat (2) applyStimulus(0, 16'h0, 0, 0, 0);
        rst = 1'b1;
        applyStimulus(0, 16'h0, 0, 0, 0);
        rst = 1'b0;
        checkResetValues("mid_rst");

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 999) < 3);
            applyStimulus($urandom_range(0, 1), 16'($urandom), $urandom_range(0, 1),
                          $urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0);
        end
        rst = 1'b0;
        repeat (30) applyStimulus(0, 16'h0, 0, 0, 0);
        checkOutput("final_drain", exp_q.size(), 0);
        checkOutput("final_idle", idle, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
